rr_mux_n: RTL and testbench

Parametrised N-channel, WIDTH-bit multiplexer with registered output and valid/ready handshakes, replacing the combinational 2:1 mux wherever several producers share one consumer. Selection is round-robin or fixed-priority (by parameter). It holds one output beat and gives 1-cycle latency at full throughput. It sits between the channel sources and a single downstream sink.

---
 rtl/rr_mux_n_pkg.sv | 5 +
 rtl/rr_mux_n_arbiter.sv | 39 +++
 rtl/rr_mux_n.sv | 47 ++++
 tb/tb_rr_mux_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_n_pkg.sv
// rr_mux_n_pkg: arbitration mode constants shared by the mux and its arbiter
package rr_mux_n_pkg;
  localparam int MODE_RR = 0;
  localparam int MODE_FIXED = 1;
endpackage

// File: rtl/rr_mux_n_arbiter.sv
// rr_arbiter: round-robin or fixed-priority one-hot arbiter with wrap pointer
module rr_arbiter
  import rr_mux_n_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE = MODE_RR,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  output logic [CHANNELS-1:0] gnt,
  output logic [SELW-1:0]     gnt_idx
);
  logic [SELW-1:0] ptr;
  logic found;
  int idx;
  // first requester at or after ptr, wrapping; ptr stays 0 in fixed mode so search starts at channel 0
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (en && !found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end
  // advance past the winner only on an actual grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (MODE == MODE_RR && found) ptr <= (gnt_idx == SELW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel arbitrated mux with one registered output beat and valid/ready handshakes
module rr_mux_n
  import rr_mux_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int MODE = MODE_RR,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);
  logic load;
  logic [CHANNELS-1:0] gnt;
  logic [SELW-1:0] gnt_idx;
  assign load = !out_valid || out_ready;
  rr_arbiter #(.CHANNELS(CHANNELS), .MODE(MODE)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(in_valid),
    .en(load && rst_n),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  assign in_ready = gnt;
  // refill the output register whenever it is empty or draining this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (load) begin
      out_valid <= |gnt;
      if (|gnt) begin
        out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
        out_sel <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: table-driven and randomized checks of rr_mux_n in both arbitration modes
module tb_rr_mux_n;
  localparam int W = 8;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [C-1:0] in_valid = '0;
  logic [C*W-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [C-1:0] r0, r1;
  logic ov0, ov1;
  logic [W-1:0] od0, od1;
  logic [1:0] os0, os1;
  int vectors = 0;
  int errors = 0;
  logic mv [2];
  logic [W-1:0] md [2];
  int ms [2];
  int mptr;
  typedef struct {
    logic [3:0] v;
    logic r;
    logic [3:0] grr;
    logic [3:0] gfx;
    int srr;
    int sfx;
    logic ov;
  } vec_t;
  vec_t tv [17];

  rr_mux_n #(.WIDTH(W), .CHANNELS(C), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(r0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(out_ready));
  rr_mux_n #(.WIDTH(W), .CHANNELS(C), .MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(r1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // winner = valid channel with the smallest circular distance from the start channel
  function automatic int pick(logic [3:0] v, int start);
    int best = -1;
    int bd = C;
    for (int c = 0; c < C; c++)
      if (v[c] && ((c - start + C) % C) < bd) begin
        bd = (c - start + C) % C;
        best = c;
      end
    return best;
  endfunction

  function automatic logic [3:0] exp_gnt(int m);
    int p;
    if (mv[m] && !out_ready) return 4'b0;
    p = pick(in_valid, m == 0 ? mptr : 0);
    return p < 0 ? 4'b0 : 4'(1 << p);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0;
      md[m] = '0;
      ms[m] = 0;
    end
    mptr = 0;
  endtask

  task automatic model_edge();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = pick(in_valid, m == 0 ? mptr : 0);
      if (!mv[m] || out_ready) begin
        if (g >= 0) begin
          mv[m] = 1'b1;
          md[m] = in_data[g*W +: W];
          ms[m] = g;
          if (m == 0) mptr = (g + 1) % C;
        end else mv[m] = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("rr_in_ready", 32'(r0), 32'(exp_gnt(0)));
    chk("fx_in_ready", 32'(r1), 32'(exp_gnt(1)));
    chk("rr_out_valid", 32'(ov0), 32'(mv[0]));
    chk("fx_out_valid", 32'(ov1), 32'(mv[1]));
    chk("rr_out_data", 32'(od0), 32'(md[0]));
    chk("fx_out_data", 32'(od1), 32'(md[1]));
    chk("rr_out_sel", 32'(os0), 32'(ms[0]));
    chk("fx_out_sel", 32'(os1), 32'(ms[1]));
  endtask

  task automatic step(output logic [3:0] taken);
    #1 check_model();
    taken = exp_gnt(0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] tk;
    tv[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 0, 0, 1'b1};
    tv[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1, 0, 1'b1};
    tv[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 2, 0, 1'b1};
    tv[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 3, 0, 1'b1};
    tv[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 0, 0, 1'b1};
    tv[5]  = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1, 1, 1'b1};
    tv[6]  = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 3, 1, 1'b1};
    tv[7]  = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1, 1, 1'b1};
    tv[8]  = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 3, 1, 1'b1};
    tv[9]  = '{4'b1110, 1'b1, 4'b0010, 4'b0010, 1, 1, 1'b1};
    tv[10] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 0, 0, 1'b1};
    tv[11] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 2, 2, 1'b1};
    tv[12] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 2, 2, 1'b1};
    tv[13] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 2, 2, 1'b1};
    tv[14] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 2, 2, 1'b1};
    tv[15] = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 3, 0, 1'b1};
    tv[16] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 3, 0, 1'b0};
    model_reset();
    in_valid = 4'b1111;
    in_data = 32'h44332211;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rr_in_ready", 32'(r0), 32'h0);
    chk("rst_fx_in_ready", 32'(r1), 32'h0);
    chk("rst_out_valid", 32'(ov0), 32'h0);
    chk("rst_out_data", 32'(od0), 32'h0);
    chk("rst_out_sel", 32'(os0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = tv[i].v;
      out_ready = tv[i].r;
      #1;
      chk($sformatf("tab%0d_rr_ready", i), 32'(r0), 32'(tv[i].grr));
      chk($sformatf("tab%0d_fx_ready", i), 32'(r1), 32'(tv[i].gfx));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tab%0d_rr_valid", i), 32'(ov0), 32'(tv[i].ov));
      chk($sformatf("tab%0d_rr_sel", i), 32'(os0), 32'(tv[i].srr));
      chk($sformatf("tab%0d_rr_data", i), 32'(od0), 32'((tv[i].srr + 1) * 17));
      chk($sformatf("tab%0d_fx_valid", i), 32'(ov1), 32'(tv[i].ov));
      chk($sformatf("tab%0d_fx_sel", i), 32'(os1), 32'(tv[i].sfx));
      chk($sformatf("tab%0d_fx_data", i), 32'(od1), 32'((tv[i].sfx + 1) * 17));
      @(negedge clk);
    end
    tk = 4'b1111;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < C; c++)
        if (tk[c] || !in_valid[c]) begin
          in_valid[c] = ($urandom_range(0, 2) != 0);
          in_data[c*W +: W] = 8'($urandom);
        end
      out_ready = ($urandom_range(0, 3) != 0);
      step(tk);
    end
    in_valid = 4'b1111;
    in_data = 32'h44332211;
    out_ready = 1'b1;
    step(tk);
    step(tk);
    #1 chk("pre_reset_valid", 32'(ov0), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("async_rst_rr_valid", 32'(ov0), 32'h0);
    chk("async_rst_fx_valid", 32'(ov1), 32'h0);
    chk("async_rst_ready", 32'(r0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1 chk("post_rst_first_grant", 32'(r0), 32'h1);
    step(tk);
    step(tk);
    step(tk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
